// File: rtl/color_vote_stabilizer.sv
// Per-frame die colour vote: classify R/G/B counts and emit one result per throw after STABLE_FRAMES agreeing frames.
// Latency: counts latched on the frame_done edge, frame_color one edge later, color_result_ready pulse two edges later.
// No backpressure: one frame per >=3 cycles. Optional watchdog: define COLOR_VOTE_WATCHDOG_EN.
module color_vote_stabilizer #(
    parameter int CNT_W          = 17,
    parameter int MIN_PIXELS     = 2000,
    parameter int MARGIN_SHIFT   = 1,
    parameter int STABLE_FRAMES  = 3,
    parameter int CLEAR_FRAMES   = 2,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             frame_done,
    input  logic [CNT_W-1:0] red_cnt,
    input  logic [CNT_W-1:0] green_cnt,
    input  logic [CNT_W-1:0] blue_cnt,
    output logic [1:0]       frame_color,
    output logic [1:0]       detected_color,
    output logic [1:0]       movement_steps,
    output logic             color_result_ready,
    output logic [15:0]      color_confidence,
    output logic             locked,
    output logic             timeout_flag
);

    localparam logic [1:0]       C_NONE   = 2'b00;
    localparam logic [1:0]       C_RED    = 2'b01;
    localparam logic [1:0]       C_GREEN  = 2'b10;
    localparam logic [1:0]       C_BLUE   = 2'b11;
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
    localparam logic [3:0]       STABLE_N = 4'(STABLE_FRAMES);
    localparam logic [3:0]       CLEAR_N  = 4'(CLEAR_FRAMES);

    typedef enum logic [1:0] {ARMED, TRACK, LOCKED} state_t;

    logic [CNT_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [1:0]       frame_color_q, frame_color_d;
    logic [CNT_W-1:0] win_q, win_d;
    state_t           state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [3:0]       run_q, run_d, clear_run_q, clear_run_d;
    logic [1:0]       detected_q, detected_d, steps_q, steps_d;
    logic [15:0]      conf_q, conf_d;
    logic             ready_q, ready_d;
    logic             emit;
    logic             wd_expire;

    logic [1:0]       cls_color, win_color;
    logic [CNT_W-1:0] cls_win, cls_second;

    // Classify the latched counts: winner with R>G>B tie priority, then threshold and margin test
    always_comb begin
        win_color  = C_RED;
        cls_win    = red_q;
        cls_second = (green_q >= blue_q) ? green_q : blue_q;
        if (red_q >= green_q && red_q >= blue_q) begin
            win_color  = C_RED;
            cls_win    = red_q;
            cls_second = (green_q >= blue_q) ? green_q : blue_q;
        end else if (green_q >= blue_q) begin
            win_color  = C_GREEN;
            cls_win    = green_q;
            cls_second = (red_q >= blue_q) ? red_q : blue_q;
        end else begin
            win_color  = C_BLUE;
            cls_win    = blue_q;
            cls_second = (red_q >= green_q) ? red_q : green_q;
        end
        cls_color = win_color;
        if (cls_win < MIN_CNT || (cls_win - cls_second) < (cls_win >> MARGIN_SHIFT))
            cls_color = C_NONE;
    end

    // Input latch and classification register; clear drops anything in flight
    always_comb begin
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        frame_color_d = frame_color_q;
        win_d         = win_q;
        s1_vld_d      = frame_done & ~clear;
        s2_vld_d      = s1_vld_q & ~clear;
        if (frame_done) begin
            red_d   = red_cnt;
            green_d = green_cnt;
            blue_d  = blue_cnt;
        end
        if (s1_vld_q) begin
            frame_color_d = cls_color;
            win_d         = cls_win;
        end
        if (clear)
            frame_color_d = C_NONE;
    end

`ifdef COLOR_VOTE_WATCHDOG_EN
    localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    // Idle-cycle counter between frames; saturates at the limit so expiry fires once
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (frame_done || clear)
            wd_cnt_d = '0;
        else if (wd_cnt_q != WD_LIMIT)
            wd_cnt_d = wd_cnt_q + 1'b1;
        wd_expire = (wd_cnt_d == WD_LIMIT) && (wd_cnt_q != WD_LIMIT) && !clear;
        timeout_d = clear ? 1'b0 : (timeout_q | wd_expire);
    end

    // Watchdog state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_flag = timeout_q;
`else
    assign wd_expire    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Vote FSM: track agreeing frames, emit once, then wait for the die to leave
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        run_d       = run_q;
        clear_run_d = clear_run_q;
        detected_d  = detected_q;
        steps_d     = steps_q;
        conf_d      = conf_q;
        ready_d     = 1'b0;
        emit        = 1'b0;
        if (s2_vld_q) begin
            case (state_q)
                ARMED: begin
                    if (frame_color_q != C_NONE) begin
                        cand_d = frame_color_q;
                        if (STABLE_N == 4'd1) begin
                            emit        = 1'b1;
                            state_d     = LOCKED;
                            run_d       = 4'd0;
                            clear_run_d = 4'd0;
                        end else begin
                            run_d   = 4'd1;
                            state_d = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (frame_color_q == C_NONE) begin
                        state_d = ARMED;
                        run_d   = 4'd0;
                        cand_d  = C_NONE;
                    end else if (frame_color_q == cand_q) begin
                        if (run_q + 4'd1 == STABLE_N) begin
                            emit        = 1'b1;
                            state_d     = LOCKED;
                            run_d       = 4'd0;
                            clear_run_d = 4'd0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        cand_d = frame_color_q;
                        run_d  = 4'd1;
                    end
                end
                LOCKED: begin
                    if (frame_color_q == C_NONE) begin
                        if (clear_run_q + 4'd1 == CLEAR_N) begin
                            state_d     = ARMED;
                            clear_run_d = 4'd0;
                            cand_d      = C_NONE;
                        end else begin
                            clear_run_d = clear_run_q + 4'd1;
                        end
                    end else begin
                        clear_run_d = 4'd0;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
        // Step count equals the colour code (RED 1, GREEN 2, BLUE 3)
        if (emit) begin
            detected_d = frame_color_q;
            steps_d    = frame_color_q;
            conf_d     = (32'(win_q) > 32'h0000_FFFF) ? 16'hFFFF : 16'(win_q);
            ready_d    = 1'b1;
        end
        if (wd_expire) begin
            state_d     = ARMED;
            run_d       = 4'd0;
            clear_run_d = 4'd0;
            cand_d      = C_NONE;
        end
        if (clear) begin
            state_d     = ARMED;
            cand_d      = C_NONE;
            run_d       = 4'd0;
            clear_run_d = 4'd0;
            detected_d  = C_NONE;
            steps_d     = 2'd0;
            conf_d      = 16'd0;
            ready_d     = 1'b0;
        end
    end

    // All pipeline and FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            s1_vld_q      <= 1'b0;
            s2_vld_q      <= 1'b0;
            frame_color_q <= C_NONE;
            win_q         <= '0;
            state_q       <= ARMED;
            cand_q        <= C_NONE;
            run_q         <= 4'd0;
            clear_run_q   <= 4'd0;
            detected_q    <= C_NONE;
            steps_q       <= 2'd0;
            conf_q        <= 16'd0;
            ready_q       <= 1'b0;
        end else begin
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            s1_vld_q      <= s1_vld_d;
            s2_vld_q      <= s2_vld_d;
            frame_color_q <= frame_color_d;
            win_q         <= win_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            run_q         <= run_d;
            clear_run_q   <= clear_run_d;
            detected_q    <= detected_d;
            steps_q       <= steps_d;
            conf_q        <= conf_d;
            ready_q       <= ready_d;
        end
    end

    assign frame_color        = frame_color_q;
    assign detected_color     = detected_q;
    assign movement_steps     = steps_q;
    assign color_result_ready = ready_q;
    assign color_confidence   = conf_q;
    assign locked             = (state_q == LOCKED);

endmodule

// File: tb/tb_color_vote_stabilizer.sv
// Directed bench for color_vote_stabilizer: reset, voting, margins, lock/re-arm, clear, async reset.
// Frames are spaced three cycles apart; the result pulse is expected two edges after the frame_done edge.
// Watchdog scenario is compiled only when COLOR_VOTE_WATCHDOG_EN is defined.
module tb_color_vote_stabilizer;

`ifdef COLOR_VOTE_WATCHDOG_EN
    localparam int TO = 100;
`else
    localparam int TO = 2500000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        frame_done = 1'b0;
    logic [16:0] red_cnt = '0, green_cnt = '0, blue_cnt = '0;
    logic [1:0]  frame_color, detected_color, movement_steps;
    logic        color_result_ready, locked, timeout_flag;
    logic [15:0] color_confidence;

    int errors = 0;
    int checks = 0;
    int early  = 0;

    color_vote_stabilizer #(
        .CNT_W(17), .MIN_PIXELS(2000), .MARGIN_SHIFT(1),
        .STABLE_FRAMES(3), .CLEAR_FRAMES(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .frame_done(frame_done),
        .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt),
        .frame_color(frame_color), .detected_color(detected_color),
        .movement_steps(movement_steps), .color_result_ready(color_result_ready),
        .color_confidence(color_confidence), .locked(locked), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: returns frame_color one edge later and the pulse two edges later
    task automatic do_frame(input logic [16:0] r, input logic [16:0] g, input logic [16:0] b,
                            output logic pulse, output logic [1:0] fc);
        red_cnt = r; green_cnt = g; blue_cnt = b; frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        if (color_result_ready) early++;
        tick();
        fc = frame_color;
        if (color_result_ready) early++;
        tick();
        pulse = color_result_ready;
    endtask

    task automatic rearm();
        logic p; logic [1:0] fc;
        do_frame(0, 0, 0, p, fc);
        do_frame(0, 0, 0, p, fc);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rearm_locked: got %0b expected 0", locked); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (color_result_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held: got %0b expected 0", color_result_ready); end
        reset = 1'b0;
        tick();
        checks++; if (frame_color !== 2'd0) begin errors++; $display("FAIL reset_frame_color: got %0d expected 0", frame_color); end
        checks++; if (detected_color !== 2'd0) begin errors++; $display("FAIL reset_detected: got %0d expected 0", detected_color); end
        checks++; if (movement_steps !== 2'd0) begin errors++; $display("FAIL reset_steps: got %0d expected 0", movement_steps); end
        checks++; if (color_confidence !== 16'd0) begin errors++; $display("FAIL reset_conf: got %0d expected 0", color_confidence); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", timeout_flag); end
    endtask

    task automatic test_stable_red();
        logic p; logic [1:0] fc;
        early = 0;
        do_frame(5000, 100, 100, p, fc);
        checks++; if (fc !== 2'd1) begin errors++; $display("FAIL red_frame_color: got %0d expected 1", fc); end
        checks++; if (p !== 1'b0) begin errors++; $display("FAIL red_pulse_f1: got %0b expected 0", p); end
        do_frame(5000, 100, 100, p, fc);
        checks++; if (p !== 1'b0) begin errors++; $display("FAIL red_pulse_f2: got %0b expected 0", p); end
        do_frame(5000, 100, 100, p, fc);
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL red_pulse_f3: got %0b expected 1", p); end
        checks++; if (detected_color !== 2'd1) begin errors++; $display("FAIL red_detected: got %0d expected 1", detected_color); end
        checks++; if (movement_steps !== 2'd1) begin errors++; $display("FAIL red_steps: got %0d expected 1", movement_steps); end
        checks++; if (color_confidence !== 16'd5000) begin errors++; $display("FAIL red_conf: got %0d expected 5000", color_confidence); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL red_locked: got %0b expected 1", locked); end
        tick();
        checks++; if (color_result_ready !== 1'b0) begin errors++; $display("FAIL red_pulse_width: got %0b expected 0", color_result_ready); end
        checks++; if (early !== 0) begin errors++; $display("FAIL red_early_pulses: got %0d expected 0", early); end
        rearm();
    endtask

    task automatic test_candidate_switch();
        logic p; logic [1:0] fc;
        int pulses = 0;
        early = 0;
        do_frame(200, 4000, 200, p, fc); pulses += int'(p);
        checks++; if (fc !== 2'd2) begin errors++; $display("FAIL switch_fc_green: got %0d expected 2", fc); end
        do_frame(200, 4000, 200, p, fc); pulses += int'(p);
        do_frame(200, 200, 4000, p, fc); pulses += int'(p);
        checks++; if (fc !== 2'd3) begin errors++; $display("FAIL switch_fc_blue: got %0d expected 3", fc); end
        do_frame(200, 200, 4000, p, fc); pulses += int'(p);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL switch_no_early: got %0d expected 0", pulses); end
        do_frame(200, 200, 4000, p, fc);
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL switch_pulse: got %0b expected 1", p); end
        checks++; if (detected_color !== 2'd3) begin errors++; $display("FAIL switch_detected: got %0d expected 3", detected_color); end
        checks++; if (movement_steps !== 2'd3) begin errors++; $display("FAIL switch_steps: got %0d expected 3", movement_steps); end
        checks++; if (color_confidence !== 16'd4000) begin errors++; $display("FAIL switch_conf: got %0d expected 4000", color_confidence); end
        checks++; if (early !== 0) begin errors++; $display("FAIL switch_early_pulses: got %0d expected 0", early); end
    endtask

    task automatic test_lock_rearm();
        logic p; logic [1:0] fc;
        int pulses = 0;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            do_frame(5000, 100, 100, p, fc);
            pulses += int'(p);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL lock_no_pulse: got %0d expected 0", pulses); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_still_locked: got %0b expected 1", locked); end
        checks++; if (detected_color !== 2'd3) begin errors++; $display("FAIL lock_held_detected: got %0d expected 3", detected_color); end
        do_frame(0, 0, 0, p, fc);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_one_empty: got %0b expected 1", locked); end
        do_frame(0, 0, 0, p, fc);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_two_empty: got %0b expected 0", locked); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            do_frame(100, 100, 5000, p, fc);
            pulses += int'(p);
        end
        checks++; if (pulses !== 1 || p !== 1'b1) begin errors++; $display("FAIL rearm_blue_pulses: got %0d (last %0b) expected 1 (last 1)", pulses, p); end
        checks++; if (detected_color !== 2'd3) begin errors++; $display("FAIL rearm_blue_detected: got %0d expected 3", detected_color); end
        rearm();
        for (int i = 0; i < 3; i++) do_frame(70000, 0, 0, p, fc);
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL sat_pulse: got %0b expected 1", p); end
        checks++; if (color_confidence !== 16'hFFFF) begin errors++; $display("FAIL sat_conf: got %0h expected ffff", color_confidence); end
        checks++; if (detected_color !== 2'd1) begin errors++; $display("FAIL sat_detected: got %0d expected 1", detected_color); end
        checks++; if (early !== 0) begin errors++; $display("FAIL lock_early_pulses: got %0d expected 0", early); end
        rearm();
    endtask

    task automatic test_margin();
        logic p; logic [1:0] fc;
        early = 0;
        do_frame(3000, 2000, 0, p, fc);
        checks++; if (fc !== 2'd0) begin errors++; $display("FAIL margin_3000_2000: got %0d expected 0", fc); end
        do_frame(1500, 0, 0, p, fc);
        checks++; if (fc !== 2'd0) begin errors++; $display("FAIL thresh_1500: got %0d expected 0", fc); end
        do_frame(4000, 4000, 0, p, fc);
        checks++; if (fc !== 2'd0) begin errors++; $display("FAIL tie_4000: got %0d expected 0", fc); end
        do_frame(1501, 3000, 0, p, fc);
        checks++; if (fc !== 2'd0) begin errors++; $display("FAIL margin_off_by_one: got %0d expected 0", fc); end
        do_frame(2000, 0, 0, p, fc);
        checks++; if (fc !== 2'd1 || p !== 1'b0) begin errors++; $display("FAIL thresh_exact: got fc %0d pulse %0b expected fc 1 pulse 0", fc, p); end
        do_frame(4000, 2000, 0, p, fc);
        checks++; if (fc !== 2'd1 || p !== 1'b0) begin errors++; $display("FAIL margin_exact: got fc %0d pulse %0b expected fc 1 pulse 0", fc, p); end
        do_frame(5000, 100, 100, p, fc);
        checks++; if (p !== 1'b1 || color_confidence !== 16'd5000) begin errors++; $display("FAIL margin_third_red: got pulse %0b conf %0d expected 1 5000", p, color_confidence); end
        checks++; if (early !== 0) begin errors++; $display("FAIL margin_early_pulses: got %0d expected 0", early); end
        rearm();
    endtask

    task automatic test_clear();
        logic p; logic [1:0] fc;
        int pulses = 0;
        early = 0;
        do_frame(5000, 100, 100, p, fc);
        do_frame(5000, 100, 100, p, fc);
        red_cnt = 5000; green_cnt = 100; blue_cnt = 100;
        frame_done = 1'b1; clear = 1'b1;
        tick();
        frame_done = 1'b0; clear = 1'b0;
        checks++; if (detected_color !== 2'd0 || movement_steps !== 2'd0) begin errors++; $display("FAIL clear_detected_steps: got %0d %0d expected 0 0", detected_color, movement_steps); end
        checks++; if (color_confidence !== 16'd0 || frame_color !== 2'd0) begin errors++; $display("FAIL clear_conf_fc: got %0d %0d expected 0 0", color_confidence, frame_color); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clear_locked: got %0b expected 0", locked); end
        tick(); pulses += int'(color_result_ready);
        tick(); pulses += int'(color_result_ready);
        checks++; if (pulses !== 0 || frame_color !== 2'd0) begin errors++; $display("FAIL clear_discard: got pulses %0d fc %0d expected 0 0", pulses, frame_color); end
        do_frame(5000, 100, 100, p, fc); pulses += int'(p);
        do_frame(5000, 100, 100, p, fc); pulses += int'(p);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL clear_two_red: got %0d expected 0", pulses); end
        do_frame(5000, 100, 100, p, fc);
        checks++; if (p !== 1'b1 || detected_color !== 2'd1) begin errors++; $display("FAIL clear_third_red: got pulse %0b det %0d expected 1 1", p, detected_color); end
        checks++; if (early !== 0) begin errors++; $display("FAIL clear_early_pulses: got %0d expected 0", early); end
        rearm();
    endtask

    task automatic test_async_reset();
        logic p; logic [1:0] fc;
        int pulses = 0;
        do_frame(5000, 100, 100, p, fc);
        do_frame(5000, 100, 100, p, fc);
        red_cnt = 5000; green_cnt = 100; blue_cnt = 100; frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(color_result_ready);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL areset_inflight: got %0d expected 0", pulses); end
        checks++; if (detected_color !== 2'd0 || color_confidence !== 16'd0) begin errors++; $display("FAIL areset_outputs: got %0d %0d expected 0 0", detected_color, color_confidence); end
        early = 0;
        do_frame(5000, 100, 100, p, fc); pulses += int'(p);
        do_frame(5000, 100, 100, p, fc); pulses += int'(p);
        do_frame(5000, 100, 100, p, fc);
        checks++; if (pulses !== 0 || p !== 1'b1) begin errors++; $display("FAIL areset_restart: got early %0d last %0b expected 0 1", pulses, p); end
        rearm();
    endtask

`ifdef COLOR_VOTE_WATCHDOG_EN
    task automatic test_watchdog();
        logic p; logic [1:0] fc;
        int pulses = 0;
        do_frame(100, 5000, 100, p, fc);
        do_frame(100, 5000, 100, p, fc);
        repeat (TO + 5) tick();
        checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL wd_flag: got %0b expected 1", timeout_flag); end
        checks++; if (detected_color !== 2'd1) begin errors++; $display("FAIL wd_held_detected: got %0d expected 1", detected_color); end
        do_frame(100, 5000, 100, p, fc); pulses += int'(p);
        do_frame(100, 5000, 100, p, fc); pulses += int'(p);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL wd_state_armed: got %0d expected 0", pulses); end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL wd_clear: got %0b expected 0", timeout_flag); end
    endtask
`endif

    initial begin
        test_reset();
        test_stable_red();
        test_candidate_switch();
        test_lock_rearm();
        test_margin();
        test_clear();
        test_async_reset();
`ifdef COLOR_VOTE_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/color_vote_stabilizer.md
Name: color_vote_stabilizer

Overview:
Sits between the per-frame color pixel counters and the game FSM. Once per frame it classifies the dominant die color from red/green/blue pixel counts and requires several consecutive agreeing frames before it emits a one-cycle result. It then locks until the die is removed, so each throw produces exactly one movement command.

Parameters:
CNT_W, 17, width of per-frame pixel counts (320x240 = 76800 max)
MIN_PIXELS, 2000, minimum winner count for a frame to classify as non-NONE
MARGIN_SHIFT, 1, winner must satisfy (winner - second) >= (winner >> MARGIN_SHIFT)
STABLE_FRAMES, 3, consecutive identical non-NONE frames needed to emit (1..15)
CLEAR_FRAMES, 2, consecutive NONE frames needed to re-arm after emit (1..15)
TIMEOUT_CYCLES, 2500000, watchdog limit between frame_done pulses (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
clear  in  1  synchronous: return to ARMED, zero held outputs
frame_done  in  1  one-cycle pulse; counts valid on this cycle
red_cnt  in  CNT_W  red pixel count of completed frame
green_cnt  in  CNT_W  green pixel count
blue_cnt  in  CNT_W  blue pixel count
frame_color  out  2  registered classification of latest frame
detected_color  out  2  last emitted color (00 NONE, 01 RED, 10 GREEN, 11 BLUE)
movement_steps  out  2  steps of last emitted color (RED 1, GREEN 2, BLUE 3)
color_result_ready  out  1  one-cycle pulse when a new result is emitted
color_confidence  out  16  winner count of the emitting frame, saturated to 16'hFFFF
locked  out  1  high in LOCKED state
timeout_flag  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset: state ARMED; all outputs 0; internal run/clear counters 0, candidate NONE.
- Stage 1 (frame_done cycle): latch counts. Stage 2 (next cycle): classify and register frame_color. Stage 3 (next cycle): FSM update. color_result_ready asserts exactly 2 cycles after the qualifying frame_done.
- Classification: winner = max count, ties broken RED > GREEN > BLUE; second = largest remaining count. Result is NONE if winner < MIN_PIXELS or (winner - second) < (winner >> MARGIN_SHIFT). Exact ties therefore always give NONE. Unsigned arithmetic at CNT_W, no overflow possible.
- ARMED: a non-NONE frame sets cand=c, run=1, and goes to TRACK. If STABLE_FRAMES==1, it instead emits immediately and goes to LOCKED.
- TRACK:
  - c==cand: run+1. Reaching STABLE_FRAMES emits and goes to LOCKED.
  - Different non-NONE c: cand=c, run=1, stay in TRACK.
  - NONE: go to ARMED, run=0.
- Emit: detected_color=cand, movement_steps=step(cand), color_confidence=sat16(winner), color_result_ready=1 for one cycle. These outputs hold until the next emit or clear.
- LOCKED: a NONE frame increments clear_run. Any non-NONE frame sets clear_run=0. clear_run==CLEAR_FRAMES goes to ARMED with clear_run=0. No emits occur while LOCKED.
- No frame_done pulse: state unchanged, no pulse.
- clear asserted: next cycle state ARMED, counters 0, detected_color/movement_steps/color_confidence/frame_color 0. Any pipelined frame in flight is discarded. clear wins over a simultaneous frame_done.
- frame_done pulses closer than 3 cycles apart are out of spec.
- Async reset mid-pipeline: in-flight frame is dropped, no pulse is generated.

Optional Feature:
Macro COLOR_VOTE_WATCHDOG_EN.
- Defined: a cycle counter clears on every frame_done. Reaching TIMEOUT_CYCLES sets timeout_flag (sticky until clear/reset), forces state ARMED, and zeroes run/clear counters. Held result outputs are not changed.
- Undefined: no counter is built and timeout_flag is tied 0.

Test Plan:
- Reset: hold reset, then release -> all outputs 0, locked=0, no pulse.
- Stable red: 3 frames red=5000, green=100, blue=100 -> after the third frame_done plus 2 cycles: one pulse, detected_color=01, movement_steps=1, color_confidence=5000, locked=1.
- Candidate switch: green, green, blue, blue, blue (each 4000 vs 200) -> single pulse after the fifth frame, detected_color=11, steps=3. No pulse earlier.
- Margin/threshold: red=3000, green=2000 -> frame_color=00. Red=1500 alone -> 00. Red=green=4000 -> 00. No state advance in any case.
- Lock/re-arm: after an emit, 5 more red frames -> no pulse. Then 2 empty frames, then 3 blue frames -> exactly one new pulse, detected_color=11. Saturation case: red=70000 -> confidence 16'hFFFF.
- clear vs frame_done same cycle in TRACK with run=2 -> state ARMED, outputs 0. The next 2 red frames give no pulse; the third red frame gives a pulse. With COLOR_VOTE_WATCHDOG_EN and TIMEOUT_CYCLES=100: 100 idle cycles -> timeout_flag=1, state ARMED.
